regfile_cmd_ctrl: RTL
=====================

# regfile_cmd_ctrl

- Command sequencer that sits between the byte-wide receive/transmit datapath and the single-port register file.
- Parses framed byte commands: write (opcode, address, data) and read (opcode, address).
- Drives the register file's address, write-enable, read-enable and write-data pins, and returns read data through a valid/busy transmit handshake.
- Flags malformed frames and read timeouts on a one-cycle error pulse.

## Interface
- `WIDTH`, 8, byte and register width
- `ADDR_WIDTH`, 4, register file address width
- `TIMEOUT`, 4, maximum cycles to wait in RD_WAIT for `RfRdValid`
- `CLK` in 1: the single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `RxData` in WIDTH: received byte.
- `RxValid` in 1: `RxData` valid this cycle, single-cycle strobe per byte.
- `TxBusy` in 1: transmitter cannot accept.
- `RfRdData` in WIDTH: register file read data.
- `RfRdValid` in 1: register file read data valid.
- `RfAddress` out ADDR_WIDTH: register file address.
- `RfWrEn` out 1: register file write strobe.
- `RfRdEn` out 1: register file read strobe.
- `RfWrData` out WIDTH: register file write data.
- `TxData` out WIDTH: read result to transmitter.
- `TxValid` out 1: `TxData` valid.
- `CmdErr` out 1: one-cycle error pulse.

## Operation
- Opcodes:
  - `WR_CMD` = 0xAA, frame is opcode, address, data.
  - `RD_CMD` = 0xBB, frame is opcode, address.
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.
- FSM states and transitions (a byte is accepted only when `RxValid`=1):
  - IDLE:
    - 0xAA → WR_ADDR.
    - 0xBB → RD_ADDR.
    - Any other byte → `CmdErr` pulse, stay in IDLE.
  - WR_ADDR:
    - If byte bits above ADDR_WIDTH are nonzero → `CmdErr`, go to IDLE.
    - Otherwise latch address, go to WR_DATA.
  - WR_DATA: drive `RfAddress`/`RfWrData`, pulse `RfWrEn` for exactly 1 cycle, go to IDLE.
  - RD_ADDR:
    - Address check as in WR_ADDR.
    - If valid, pulse `RfRdEn` for 1 cycle with `RfAddress`, go to RD_WAIT.
  - RD_WAIT:
    - On `RfRdValid`, capture `RfRdData` into `TxData`, go to TX_SEND.
    - Wait counter counts cycles in this state; on reaching TIMEOUT without valid → `CmdErr`, go to IDLE.
  - TX_SEND: hold `TxValid`=1 with `TxData` stable until a cycle with `TxBusy`=0, then go to IDLE.
- `RxValid` in RD_WAIT or TX_SEND: byte dropped and `CmdErr` pulsed; current transaction continues.
- Invariants:
  - `RfWrEn` and `RfRdEn` are never high in the same cycle.
  - Each strobe is high for at most 1 consecutive cycle.
- `RfAddress` holds its last value between commands.
- `TxData` holds its last value after the transfer.

## Timing
- Write: data byte accepted in cycle n → `RfWrEn`=1 in cycle n+1 only.
- Read, address accepted in cycle n:
  - `RfRdEn` in n+1.
  - Register file returns `RfRdValid` in n+2.
  - `TxValid` rises in n+3.
- Transmit handshake: transfer completes in the first cycle with `TxValid`=1 and `TxBusy`=0. `TxValid` is 0 the following cycle, and the FSM is in IDLE the same cycle.
- Back-to-back frames: a new opcode may be accepted in the cycle after `RfWrEn`, or in the cycle after the transmit transfer.
- Timeout: `CmdErr` is asserted in the cycle after the TIMEOUT-th RD_WAIT cycle without `RfRdValid`.
  - Wait counter width is clog2(TIMEOUT+1).
  - The counter clears on entering RD_WAIT.
- Reset mid-frame (any state):
  - All outputs go to 0 asynchronously; state returns to IDLE.
  - The partial frame is discarded; no strobe is issued after release.

## Structure
- Shared package `regfile_ctrl_pkg` holds:
  - the state enum (IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND);
  - the opcode constants `WR_CMD` and `RD_CMD`.
- Single module with no sub-module: the FSM, the address/data capture registers and the timeout counter stay in one block.

## Test plan
- Write: RX 0xAA, 0x05, 0x3C → one `RfWrEn` pulse with `RfAddress`=5, `RfWrData`=0x3C; `CmdErr` stays 0.
- Read: RX 0xBB, 0x02; register file model returns 0x81 → `RfRdEn` pulse with `RfAddress`=2; `TxData`=0x81, `TxValid` at n+3.
- Transmit back-pressure: in the read above, hold `TxBusy`=1 for 5 cycles → `TxValid`/`TxData` stable throughout; `TxValid` drops the cycle after `TxBusy` falls.
- Errors:
  - RX 0x12 in IDLE → `CmdErr` pulse.
  - RX 0xAA, 0x1F → `CmdErr` pulse, no `RfWrEn`.
  - Stub never asserts `RfRdValid` → `CmdErr` after 4 RD_WAIT cycles, back to IDLE.
- Reset: assert `RST` after 0xAA, 0x05, then release and send 0x3C → no `RfWrEn`; 0x3C is treated as a bad opcode and `CmdErr` pulses.

Source files
------------

// File: rtl/regfile_cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg : shared FSM state encoding and command opcodes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

endpackage

`default_nettype wire

// File: rtl/regfile_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_cmd_ctrl_if : byte RX/TX and register file pins of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_cmd_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);

    logic [WIDTH-1:0]      RxData;
    logic                  RxValid;
    logic                  TxBusy;
    logic [WIDTH-1:0]      RfRdData;
    logic                  RfRdValid;
    logic [ADDR_WIDTH-1:0] RfAddress;
    logic                  RfWrEn;
    logic                  RfRdEn;
    logic [WIDTH-1:0]      RfWrData;
    logic [WIDTH-1:0]      TxData;
    logic                  TxValid;
    logic                  CmdErr;

    // Sequencer side
    modport master (
        input  RxData, RxValid, TxBusy, RfRdData, RfRdValid,
        output RfAddress, RfWrEn, RfRdEn, RfWrData, TxData, TxValid, CmdErr
    );

    // Datapath / register file side
    modport slave (
        output RxData, RxValid, TxBusy, RfRdData, RfRdValid,
        input  RfAddress, RfWrEn, RfRdEn, RfWrData, TxData, TxValid, CmdErr
    );

endinterface

`default_nettype wire

// File: rtl/regfile_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_cmd_ctrl : framed byte command sequencer for a single-port regfile
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_cmd_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    regfile_cmd_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q,   rf_addr_d;
    logic [WIDTH-1:0]      rf_wdata_q,  rf_wdata_d;
    logic                  rf_wren_q,   rf_wren_d;
    logic                  rf_rden_q,   rf_rden_d;
    logic [WIDTH-1:0]      tx_data_q,   tx_data_d;
    logic                  tx_valid_q,  tx_valid_d;
    logic                  cmd_err_q,   cmd_err_d;

    logic                  w_addr_bad;

    // Address bytes must fit in the register file address space
    assign w_addr_bad = |bus.RxData[WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_wren_q  <= 1'b0;
            rf_rden_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_wren_q  <= rf_wren_d;
            rf_rden_q  <= rf_rden_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        rf_addr_d  = rf_addr_q;
        rf_wdata_d = rf_wdata_q;
        rf_wren_d  = 1'b0;
        rf_rden_d  = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        cmd_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.RxValid) begin
                    if (bus.RxData == WIDTH'(WR_CMD)) begin
                        state_d = WR_ADDR;
                    end else if (bus.RxData == WIDTH'(RD_CMD)) begin
                        state_d = RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (bus.RxValid) begin
                    if (w_addr_bad) begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        addr_d  = bus.RxData[ADDR_WIDTH-1:0];
                        state_d = WR_DATA;
                    end
                end
            end

            WR_DATA: begin
                if (bus.RxValid) begin
                    rf_addr_d  = addr_q;
                    rf_wdata_d = bus.RxData;
                    rf_wren_d  = 1'b1;
                    state_d    = IDLE;
                end
            end

            RD_ADDR: begin
                if (bus.RxValid) begin
                    if (w_addr_bad) begin
                        cmd_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rf_addr_d = bus.RxData[ADDR_WIDTH-1:0];
                        rf_rden_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // Stray bytes are dropped but the read keeps going
                if (bus.RxValid) begin
                    cmd_err_d = 1'b1;
                end
                if (bus.RfRdValid) begin
                    tx_data_d  = bus.RfRdData;
                    tx_valid_d = 1'b1;
                    state_d    = TX_SEND;
                end else if (cnt_q == TO_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            TX_SEND: begin
                if (bus.RxValid) begin
                    cmd_err_d = 1'b1;
                end
                if (!bus.TxBusy) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.RfAddress = rf_addr_q;
    assign bus.RfWrData  = rf_wdata_q;
    assign bus.RfWrEn    = rf_wren_q;
    assign bus.RfRdEn    = rf_rden_q;
    assign bus.TxData    = tx_data_q;
    assign bus.TxValid   = tx_valid_q;
    assign bus.CmdErr    = cmd_err_q;

endmodule

`default_nettype wire
